// File: rtl/codec_reg_arbiter.sv
// ============================================================================
// Module   : codec_reg_arbiter
// Purpose  : Round-robin arbiter that funnels NUM_REQ codec register writers
//            onto one SPI master, generates the CS latch pulse and keeps a
//            readable shadow of the write-only codec registers.
//            Optional: CODEC_WRITE_DEDUP_EN skips writes that match the shadow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module codec_reg_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CS_HOLD = 2,
    parameter int GAP     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [9*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 err,
    output logic [15:0]          spi_data,
    output logic                 spi_trg,
    input  logic                 spi_rdy,
    output logic                 cs,
    output logic                 busy,
    input  logic [3:0]           rd_addr,
    output logic [8:0]           rd_data
);

    localparam int c_IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_IW1     = c_IW + 1;
    localparam int c_CNT_MAX = (CS_HOLD > GAP) ? CS_HOLD : GAP;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam int c_NREG    = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_LATCH = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_IW-1:0]      r_grant;
    logic [c_IW-1:0]      r_last;
    logic [6:0]           r_addr;
    logic [8:0]           r_data;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_err;
    logic                 r_trg;
    logic [15:0]          r_spi_data;
    logic                 r_cs;
    logic                 r_busy;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_fall_seen;
    logic [8:0]           r_shadow [0:c_NREG-1];
    logic [8:0]           r_rd_data;

    logic                 w_found;
    logic [c_IW1-1:0]     w_cand;
    logic [c_IW-1:0]      w_grant_idx;
    logic [6:0]           w_sel_addr;
    logic [8:0]           w_sel_data;
    logic [NUM_REQ-1:0]   w_grant_oh;
    logic                 w_addr_ok;
    logic                 w_dup;
    logic                 w_grant;
    logic                 w_ack_set;
    logic                 w_err_set;
    logic                 w_trg_set;
    logic                 w_wr;
    logic                 w_reload;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;

    function automatic logic [8:0] f_default(input int idx);
        case (idx)
            0, 1:    f_default = 9'h097;
            2, 3:    f_default = 9'h079;
            4, 7:    f_default = 9'h00A;
            5:       f_default = 9'h008;
            6:       f_default = 9'h09F;
            default: f_default = 9'h000;
        endcase
    endfunction

    // Search starts one past the last served requester, wrapping once.
    always_comb begin
        w_found     = 1'b0;
        w_cand      = '0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_last} + c_IW1'(k + 1);
            if (w_cand >= c_IW1'(NUM_REQ)) begin
                w_cand = w_cand - c_IW1'(NUM_REQ);
            end
            if (!w_found && req[w_cand[c_IW-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand[c_IW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == c_IW'(i)) begin
                w_sel_addr = req_addr[7*i +: 7];
                w_sel_data = req_data[9*i +: 9];
            end
        end
    end

    assign w_grant_oh = NUM_REQ'(1) << r_grant;
    assign w_addr_ok  = (r_addr <= 7'd9) || (r_addr == 7'h0F);

`ifdef CODEC_WRITE_DEDUP_EN
    logic [8:0] w_shadow_cur;

    always_comb begin
        w_shadow_cur = '0;
        for (int i = 0; i < c_NREG; i++) begin
            if (r_addr == 7'(i)) begin
                w_shadow_cur = r_shadow[i];
            end
        end
    end

    // 0x0F never matches the first term, so a codec reset is always sent.
    assign w_dup = (r_addr <= 7'd9) && (r_data == w_shadow_cur);
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ack_set   = 1'b0;
        w_err_set   = 1'b0;
        w_trg_set   = 1'b0;
        w_wr        = 1'b0;
        w_reload    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Hold off one cycle while ack is out so the requester can drop req.
                if (w_found && (r_ack == '0)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!w_addr_ok) begin
                    w_ack_set   = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_dup) begin
                    w_ack_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (spi_rdy) begin
                    w_trg_set   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_fall_seen && spi_rdy) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                if (r_cnt == c_CW'(CS_HOLD - 1)) begin
                    if (r_addr == 7'h0F) begin
                        w_reload = 1'b1;
                    end else begin
                        w_wr = 1'b1;
                    end
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_CW'(GAP - 1)) begin
                    w_ack_set   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant     <= '0;
            r_last      <= c_IW'(NUM_REQ - 1);
            r_addr      <= '0;
            r_data      <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_trg       <= 1'b0;
            r_spi_data  <= '0;
            r_cs        <= 1'b1;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_fall_seen <= 1'b0;
        end else begin
            r_ack  <= w_ack_set ? w_grant_oh : '0;
            r_err  <= w_err_set;
            r_trg  <= w_trg_set;
            r_cs   <= (w_state_nxt != S_LATCH);
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_grant) begin
                r_grant <= w_grant_idx;
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
            end
            if (w_ack_set) begin
                r_last <= r_grant;
            end
            // A rising rdy only counts once the master has shown it went busy.
            if (w_trg_set) begin
                r_spi_data  <= {r_addr, r_data};
                r_fall_seen <= 1'b0;
            end else if ((r_state == S_SHIFT) && !spi_rdy) begin
                r_fall_seen <= 1'b1;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_shadow[i] <= f_default(i);
            end
            r_rd_data <= '0;
        end else begin
            if (w_reload) begin
                for (int i = 0; i < c_NREG; i++) begin
                    r_shadow[i] <= f_default(i);
                end
            end else if (w_wr) begin
                for (int i = 0; i < c_NREG; i++) begin
                    if (r_addr == 7'(i)) begin
                        r_shadow[i] <= r_data;
                    end
                end
            end
            r_rd_data <= '0;
            for (int i = 0; i < c_NREG; i++) begin
                if (rd_addr == 4'(i)) begin
                    r_rd_data <= r_shadow[i];
                end
            end
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign spi_data = r_spi_data;
    assign spi_trg  = r_trg;
    assign cs       = r_cs;
    assign busy     = r_busy;
    assign rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_codec_reg_arbiter.sv
// ============================================================================
// Module   : tb_codec_reg_arbiter
// Purpose  : Directed self-checking bench for codec_reg_arbiter with a simple
//            SPI master model (rdy low for 16 cycles after each trigger).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_codec_reg_arbiter;

    localparam int N = 3;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [7*N-1:0] req_addr;
    logic [9*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic           err;
    logic [15:0]    spi_data;
    logic           spi_trg;
    logic           spi_rdy;
    logic           cs;
    logic           busy;
    logic [3:0]     rd_addr;
    logic [8:0]     rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_trg = 0;
    int n_ack = 0;
    int n_bad_cs = 0;
    int n_multi_ack = 0;
    int t_ack = 0;
    int t_cs_rise = 0;
    int cs_low_len = 0;
    int last_cs_low = 0;
    logic        prev_cs = 1'b1;
    logic [15:0] last_word = '0;
    logic [N-1:0] last_ack = '0;
    logic        last_err = 1'b0;
    int ack_q[$];

    codec_reg_arbiter #(.NUM_REQ(N), .CS_HOLD(2), .GAP(4)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .spi_data (spi_data),
        .spi_trg  (spi_trg),
        .spi_rdy  (spi_rdy),
        .cs       (cs),
        .busy     (busy),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        spi_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (spi_trg === 1'b1) begin
                spi_rdy = 1'b0;
                repeat (16) @(negedge clk);
                spi_rdy = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock step; observes DUT outputs on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (spi_trg === 1'b1) begin
            n_trg++;
            last_word = spi_data;
        end
        if (ack !== '0) begin
            n_ack++;
            t_ack    = cyc;
            last_ack = ack;
            last_err = err;
            if ($countones(ack) != 1) n_multi_ack++;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) ack_q.push_back(i);
            end
        end
        if (cs === 1'b0) begin
            cs_low_len++;
        end else if (prev_cs === 1'b0) begin
            last_cs_low = cs_low_len;
            if (cs_low_len != 2) n_bad_cs++;
            cs_low_len = 0;
            t_cs_rise  = cyc;
        end
        prev_cs = cs;
    endtask

    task automatic do_write(input int idx, input logic [6:0] a, input logic [8:0] d);
        bit got;
        int k;
        req_addr[7*idx +: 7] = a;
        req_data[9*idx +: 9] = d;
        req[idx] = 1'b1;
        got = 1'b0;
        k = 0;
        while (!got && k < 300) begin
            tick();
            if (ack[idx] === 1'b1) got = 1'b1;
            k++;
        end
        req[idx] = 1'b0;
        if (!got) check($sformatf("ack_timeout_req%0d", idx), 0, 1);
    endtask

    task automatic read_shadow(input logic [3:0] a, output logic [8:0] v);
        rd_addr = a;
        tick();
        v = rd_data;
    endtask

    initial begin
        logic [8:0] v;
        int n0;
        int c0;
        int qs;
        int k;
        bit got;

        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        rd_addr  = '0;

        tick();
        check("rst_cs", cs, 1);
        check("rst_trg", spi_trg, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_spi_data", spi_data, 0);
        check("rst_rd_data", rd_data, 0);
        tick();
        reset = 1'b0;

        read_shadow(4'd0, v);  check("dflt_r0", v, 9'h097);
        read_shadow(4'd2, v);  check("dflt_r2", v, 9'h079);
        read_shadow(4'd6, v);  check("dflt_r6", v, 9'h09F);
        read_shadow(4'd9, v);  check("dflt_r9", v, 9'h000);
        read_shadow(4'd12, v); check("rd_oob", v, 9'h000);

        // Single write through requester 0.
        n0 = n_trg;
        do_write(0, 7'h04, 9'h012);
        check("sw_trg_count", n_trg - n0, 1);
        check("sw_word", last_word, 16'h0812);
        check("sw_cs_low", last_cs_low, 2);
        check("sw_cs_high", t_ack - t_cs_rise, 4);
        check("sw_ack", last_ack, 3'b001);
        check("sw_err", last_err, 0);
        read_shadow(4'd4, v);  check("sw_r4", v, 9'h012);

        // Invalid address from requester 1.
        n0 = n_trg;
        c0 = cyc;
        do_write(1, 7'h0B, 9'h055);
        check("inv_latency", t_ack - c0, 2);
        check("inv_ack", last_ack, 3'b010);
        check("inv_err", last_err, 1);
        repeat (3) tick();
        check("inv_no_trg", n_trg - n0, 0);
        read_shadow(4'd3, v);  check("inv_r3", v, 9'h079);
        read_shadow(4'd4, v);  check("inv_r4", v, 9'h012);

        // Write R7, then codec reset via address 0x0F.
        do_write(2, 7'h07, 9'h042);
        read_shadow(4'd7, v);  check("cr_r7_written", v, 9'h042);
        do_write(0, 7'h0F, 9'h000);
        check("cr_word", last_word, 16'h1E00);
        read_shadow(4'd7, v);  check("cr_r7_default", v, 9'h00A);
        read_shadow(4'd4, v);  check("cr_r4_default", v, 9'h00A);

        // Asynchronous reset while the SPI master is shifting.
        n0 = n_trg;
        req_addr[6:0] = 7'h05;
        req_data[8:0] = 9'h0AA;
        req[0] = 1'b1;
        k = 0;
        while (n_trg == n0 && k < 50) begin
            tick();
            k++;
        end
        check("ar_trg_seen", n_trg - n0, 1);
        repeat (3) tick();
        check("ar_busy_pre", busy, 1);
        #2;
        reset  = 1'b1;
        req[0] = 1'b0;
        req_addr[20:14] = 7'h08;
        req_data[26:18] = 9'h1AB;
        req[2] = 1'b1;
        #1;
        check("ar_cs", cs, 1);
        check("ar_trg", spi_trg, 0);
        check("ar_busy", busy, 0);
        check("ar_ack", ack, 0);
        n0 = n_ack;
        tick();
        tick();
        reset = 1'b0;
        check("ar_no_ack", n_ack - n0, 0);
        got = 1'b0;
        k = 0;
        while (!got && k < 200) begin
            tick();
            if (ack !== '0) got = 1'b1;
            k++;
        end
        req[2] = 1'b0;
        check("ar_first_ack", ack, 3'b100);
        read_shadow(4'd5, v);  check("ar_r5_default", v, 9'h008);
        read_shadow(4'd8, v);  check("ar_r8_written", v, 9'h1AB);

        // Contention: all requesters held high from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_addr = {7'h03, 7'h02, 7'h01};
        req_data = {9'h033, 9'h022, 9'h011};
        n0 = n_trg;
        qs = ack_q.size();
        req = 3'b111;
        k = 0;
        while ((ack_q.size() - qs) < 6 && k < 600) begin
            tick();
            k++;
        end
        req = '0;
        check("rr_ack_count", ack_q.size() - qs, 6);
        for (int i = 0; i < 6; i++) begin
            if (qs + i < ack_q.size()) check($sformatf("rr_order%0d", i), ack_q[qs + i], i % 3);
        end
`ifdef CODEC_WRITE_DEDUP_EN
        check("rr_trg_count", n_trg - n0, 3);
`else
        check("rr_trg_count", n_trg - n0, 6);
`endif
        read_shadow(4'd2, v);  check("rr_r2", v, 9'h022);

        // Write of a value already held in the shadow.
        tick();
        n0 = n_trg;
        do_write(1, 7'h06, 9'h09F);
        check("dd_ack", last_ack, 3'b010);
        check("dd_err", last_err, 0);
`ifdef CODEC_WRITE_DEDUP_EN
        repeat (3) tick();
        check("dd_no_trg", n_trg - n0, 0);
`else
        check("dd_trg", n_trg - n0, 1);
        check("dd_word", last_word, 16'h0C9F);
`endif
        read_shadow(4'd6, v);  check("dd_r6", v, 9'h09F);

        check("one_hot_acks", n_multi_ack, 0);
        check("cs_pulse_len", n_bad_cs, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/codec_reg_arbiter.md
Name: codec_reg_arbiter

Overview:
- Shares the codec's single SPI control path between NUM_REQ independent register writers, e.g. the boot configurator, a volume/mute controller and a sample-rate switcher.
- Arbitrates the writers round-robin and hands each granted 16-bit word {addr[6:0], data[8:0]} to the existing SPI master through its DATA/TRG/RDY handshake.
- Generates the codec CS latch pulse after each word.
- Keeps a shadow copy of the write-only codec registers so the rest of the design can read back the current configuration.

Parameters:
- NUM_REQ, 3, number of requester ports (2..8).
- CS_HOLD, 2, clk cycles CS is held low to latch a word (>=1).
- GAP, 4, clk cycles CS is held high after the latch, before the next grant (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  write request, one bit per requester; held until the matching ack.
- req_addr  in  7*NUM_REQ  register address; requester i uses bits [7i+6:7i].
- req_data  in  9*NUM_REQ  register data; requester i uses bits [9i+8:9i].
- ack  out  NUM_REQ  one-cycle completion pulse per requester.
- err  out  1  one-cycle pulse, coincident with ack, when the address was invalid.
- spi_data  out  16  word presented to the SPI master.
- spi_trg  out  1  one-cycle start pulse to the SPI master.
- spi_rdy  in  1  SPI master idle flag.
- cs  out  1  codec chip select latch, idle high.
- busy  out  1  high in every state except IDLE.
- rd_addr  in  4  shadow readback index (0..9).
- rd_data  out  9  registered shadow value, 1-cycle latency; 0 when rd_addr > 9.

Behaviour:

Reset (asynchronous), applied at any time including mid-transfer:
- Outputs: cs=1, spi_trg=0, ack=0, err=0, busy=0, spi_data=0, rd_data=0.
- FSM to IDLE; round-robin pointer set so requester 0 has first priority.
- Shadow loaded with codec power-on defaults: R0=0x097, R1=0x097, R2=0x079, R3=0x079, R4=0x00A, R5=0x008, R6=0x09F, R7=0x00A, R8=0x000, R9=0x000.
- A transfer in progress is abandoned with no ack.

IDLE:
- If any req bit is set, grant the first set bit starting at (last_grant+1) mod NUM_REQ.
- Capture that requester's addr/data into internal registers; requester inputs are ignored from then on.
- Go to CHECK.

CHECK, 1 cycle:
- Address valid means 0x00..0x09 or 0x0F.
- Invalid address: pulse ack[g] and err; no SPI activity, shadow unchanged; return to IDLE.
- Valid address: go to LOAD.

LOAD:
- Wait for spi_rdy=1.
- Then drive spi_data={addr,data}, pulse spi_trg for exactly 1 cycle, go to SHIFT.

SHIFT:
- Wait for spi_rdy to fall, then rise. A rise is accepted only after a fall has been seen.
- Then go to LATCH.

LATCH:
- cs=0 for CS_HOLD cycles.
- On the final cycle, update the shadow:
  - addr 0x00..0x09: shadow[addr] <= data.
  - addr 0x0F: shadow reloads its reset defaults.
- Go to GAP.

GAP:
- cs=1 for GAP cycles.
- On the last cycle pulse ack[g], set last_grant=g, return to IDLE.

Request handling rules:
- A requester sampled in IDLE with req still high after its ack is re-arbitrated normally.
- The ack-to-next-grant minimum is 1 cycle.
- A req deasserted after grant does not cancel the transfer; ack is still issued.
- Simultaneous requests are served strictly round-robin, so no requester waits more than NUM_REQ-1 transfers.

Readback:
- If a shadow write and rd_addr hit the same register in the same cycle, rd_data returns the old value that cycle and the new value the next cycle.

Optional Feature:
- Macro: CODEC_WRITE_DEDUP_EN.
- Defined:
  - In CHECK, a valid write with addr 0x00..0x09 whose data equals shadow[addr] is skipped: ack[g] pulses the next cycle, then return to IDLE.
  - No spi_trg, cs stays high, err=0.
  - Address 0x0F is never skipped.
- Undefined: every valid write is sent to the SPI master.

Test Plan:
- Single write: requester 0 writes addr 0x04, data 0x012; the SPI master model returns rdy low for 16 cycles. Required: spi_data=0x0812, one spi_trg pulse, cs low for 2 cycles, then high for 4 cycles, ack[0] pulse, shadow index 4 reads 0x012.
- Contention: req=3'b111 held continuously. Required: grants in order 0,1,2,0,1,2; exactly one ack per transfer; cs pulses never overlap.
- Invalid address: requester 1 writes addr 0x0B. Required: ack[1] and err pulse together 2 cycles after req; no spi_trg; shadow unchanged.
- Codec reset: write R7=0x042, then addr 0x0F data 0x000. Required: R7 reads 0x00A after the second ack; spi_data=0x1E00 was sent.
- Asynchronous reset asserted during SHIFT. Required: cs=1, spi_trg=0, busy=0 immediately; no ack; after release, a pending req[2] is served first if req[0] is low.
- Dedup, with CODEC_WRITE_DEDUP_EN defined: write R6=0x09F (the default). Required: ack with no spi_trg. With the macro undefined, the same write produces a full SPI transfer.
